// File: rtl/timer_array.sv
// Multi-channel down-counter/timer with per-channel prescaler, mode and interrupt
// enable; sticky pending flags are combined into a single registered IRQ.
module timer_array #(
  parameter int CH = 3,
  parameter int W  = 32,
  parameter int AW = (($clog2(CH) + 2) < 3) ? 3 : ($clog2(CH) + 2)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CH-1:0] tick_out,
  output logic          irq
);

  localparam int CW = AW - 2;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;

  logic [CW-1:0] sel_ch;
  logic [1:0]    sel_reg;
  logic          sel_ok;
  logic [15:0]   wd_lo;
  logic          wd_unused;

  assign sel_ch    = addr[AW-1:2];
  assign sel_reg   = addr[1:0];
  assign sel_ok    = (32'(sel_ch) < 32'(CH));
  assign wd_lo     = 16'(wdata);
  assign wd_unused = ^wd_lo[7:4];

  logic [W-1:0]  load_q  [CH];
  logic [W-1:0]  load_d  [CH];
  logic [W-1:0]  count_q [CH];
  logic [W-1:0]  count_d [CH];
  logic [7:0]    pre_q   [CH];
  logic [7:0]    pre_d   [CH];
  logic [7:0]    p_q     [CH];
  logic [7:0]    p_d     [CH];
  logic [1:0]    mode_q  [CH];
  logic [1:0]    mode_d  [CH];
  logic [CH-1:0] en_q, en_d;
  logic [CH-1:0] ie_q, ie_d;
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] tick_q, tick_d;
  logic          irq_q, irq_d;

  always_comb begin : next_state
    logic hit, load_we, ctrl_we, clr_we, step, expiry;
    hit     = 1'b0;
    load_we = 1'b0;
    ctrl_we = 1'b0;
    step    = 1'b0;
    expiry  = 1'b0;
    clr_we  = we && sel_ok && (sel_reg == REG_STATUS);
    en_d    = en_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    tick_d  = tick_q;
    for (int i = 0; i < CH; i++) begin
      load_d[i]  = load_q[i];
      count_d[i] = count_q[i];
      pre_d[i]   = pre_q[i];
      p_d[i]     = p_q[i];
      mode_d[i]  = mode_q[i];

      hit     = we && sel_ok && (sel_ch == CW'(i));
      load_we = hit && (sel_reg == REG_LOAD);
      ctrl_we = hit && (sel_reg == REG_CTRL);
      // A LOAD/CTRL write landing on a step cycle swallows that step entirely.
      step    = en_q[i] && (p_q[i] == pre_q[i]) && !load_we && !ctrl_we;
      expiry  = step && (count_q[i] == '0);

      if (en_q[i]) p_d[i] = (p_q[i] == pre_q[i]) ? 8'd0 : p_q[i] + 8'd1;

      if (step) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - W'(1);
        end else if (mode_q[i] == MODE_PERIODIC || mode_q[i] == MODE_SQUARE) begin
          count_d[i] = load_q[i];
        end else begin
          en_d[i] = 1'b0;
        end
      end

      tick_d[i] = (mode_q[i] == MODE_SQUARE) ? (tick_q[i] ^ expiry) : expiry;

      // Expiry beats a coincident write-1-to-clear.
      if (clr_we && wd_lo[i]) pend_d[i] = 1'b0;
      if (expiry) pend_d[i] = 1'b1;

      if (load_we) begin
        load_d[i]  = wdata;
        count_d[i] = wdata;
        p_d[i]     = 8'd0;
      end
      if (ctrl_we) begin
        en_d[i]   = wd_lo[0];
        mode_d[i] = wd_lo[2:1];
        ie_d[i]   = wd_lo[3];
        pre_d[i]  = wd_lo[15:8];
        p_d[i]    = 8'd0;
        tick_d[i] = 1'b0;
      end
    end
    irq_d = |(pend_d & ie_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        load_q[i]  <= '0;
        count_q[i] <= '0;
        pre_q[i]   <= '0;
        p_q[i]     <= '0;
        mode_q[i]  <= '0;
      end
      en_q   <= '0;
      ie_q   <= '0;
      pend_q <= '0;
      tick_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        load_q[i]  <= load_d[i];
        count_q[i] <= count_d[i];
        pre_q[i]   <= pre_d[i];
        p_q[i]     <= p_d[i];
        mode_q[i]  <= mode_d[i];
      end
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin : readback
    rdata = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel_ok && (sel_ch == CW'(i))) begin
        case (sel_reg)
          REG_LOAD:  rdata = load_q[i];
          REG_CTRL:  rdata = W'({16'd0, pre_q[i], 4'd0, ie_q[i], mode_q[i], en_q[i]});
          REG_COUNT: rdata = count_q[i];
          default:   rdata = W'(pend_q);
        endcase
      end
    end
  end

  assign tick_out = tick_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: expected ticks, pending, count and EN are derived from
// expiry-time arithmetic ((load+1)*(pre+1) cycle periods) rather than a cycle model.
module tb_timer_array;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        we_a;
  logic [3:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic [2:0]  tick_a;
  logic        irq_a;

  logic        we_b;
  logic [4:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;
  logic [7:0]  tick_b;
  logic        irq_b;

  timer_array #(.CH(3), .W(32)) dut_a (
    .clk(clk), .rstn(rstn), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .tick_out(tick_a), .irq(irq_a)
  );

  timer_array #(.CH(8), .W(16)) dut_b (
    .clk(clk), .rstn(rstn), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .tick_out(tick_b), .irq(irq_b)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  function automatic int n_exp(int k, int e, int mode);
    if (k <= 0) return 0;
    if (mode == 1 || mode == 2) return k / e;
    return (k >= e) ? 1 : 0;
  endfunction

  function automatic bit is_exp(int k, int e, int mode);
    return n_exp(k, e, mode) != n_exp(k - 1, e, mode);
  endfunction

  function automatic bit exp_tick(int k, int e, int mode);
    if (mode == 2) return (n_exp(k, e, mode) % 2) == 1;
    return is_exp(k, e, mode);
  endfunction

  function automatic int exp_count(int k, int load, int pre, int mode);
    int steps;
    steps = k / (pre + 1);
    if (mode == 1 || mode == 2) return load - (steps % (load + 1));
    return (steps <= load) ? load - steps : 0;
  endfunction

  // ---------------- drivers ----------------
  task automatic wr_a(input int ch, input int rg, input logic [31:0] d);
    addr_a = {2'(ch), 2'(rg)}; wdata_a = d; we_a = 1'b1;
    @(negedge clk);
    we_a = 1'b0;
  endtask

  task automatic rd_a(input int ch, input int rg, output logic [31:0] d);
    we_a = 1'b0; addr_a = {2'(ch), 2'(rg)};
    #1;
    d = rdata_a;
  endtask

  task automatic wr_b(input int ch, input int rg, input logic [15:0] d);
    addr_b = {3'(ch), 2'(rg)}; wdata_b = d; we_b = 1'b1;
    @(negedge clk);
    we_b = 1'b0;
  endtask

  task automatic rd_b(input int ch, input int rg, output logic [15:0] d);
    we_b = 1'b0; addr_b = {3'(ch), 2'(rg)};
    #1;
    d = rdata_b;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    we_a = 1'b0; addr_a = '0; wdata_a = '0;
    we_b = 1'b0; addr_b = '0; wdata_b = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (tick_a !== 3'b000 || irq_a !== 1'b0) begin
      failures++; $display("FAIL por_outputs tick=%b irq=%b required 000/0", tick_a, irq_a);
    end
    for (int rg = 0; rg < 4; rg++) begin
      rd_a(0, rg, d);
      checks++; if (d !== 32'd0) begin
        failures++; $display("FAIL por_read reg%0d got=%h required 0", rg, d);
      end
    end
    wr_a(0, 0, 32'd4);
    wr_a(0, 1, 32'h0000_000B);
    repeat (5) @(negedge clk);
    checks++; if (tick_a[0] !== 1'b1 || irq_a !== 1'b1) begin
      failures++; $display("FAIL pre_reset_running tick=%b irq=%b required 1/1", tick_a[0], irq_a);
    end
    #2 rstn = 1'b0;
    #1;
    checks++; if (tick_a !== 3'b000 || irq_a !== 1'b0) begin
      failures++; $display("FAIL async_reset_outputs tick=%b irq=%b required 000/0", tick_a, irq_a);
    end
    rd_a(0, 2, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL async_reset_count got=%h required 0", d); end
    rd_a(0, 1, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL async_reset_ctrl got=%h required 0", d); end
    rd_a(0, 3, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL async_reset_status got=%h required 0", d); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (tick_a !== 3'b000 || irq_a !== 1'b0) begin
        failures++; $display("FAIL post_reset_quiet k=%0d tick=%b irq=%b required 000/0", k, tick_a, irq_a);
      end
    end
    for (int rg = 0; rg < 4; rg++) begin
      rd_a(0, rg, d);
      checks++; if (d !== 32'd0) begin
        failures++; $display("FAIL post_reset_read reg%0d got=%h required 0", rg, d);
      end
    end
  endtask

  // One channel programmed from reset, checked every cycle for ncyc cycles;
  // clr_k>0 issues a STATUS clear effective at edge clr_k.
  task automatic test_channel_run(input string name, input int ch, input int load, input int pre,
                                  input int mode, input bit ie, input int ncyc, input int clr_k);
    int e;
    bit pend;
    bit en_exp;
    logic [2:0]  tvec;
    logic [31:0] d, st_exp;
    do_reset();
    e = (load + 1) * (pre + 1);
    pend = 1'b0;
    wr_a(ch, 0, 32'(load));
    wr_a(ch, 1, {16'd0, 8'(pre), 4'd0, 1'(ie), 2'(mode), 1'b1});
    for (int k = 1; k <= ncyc; k++) begin
      if (k == clr_k) begin
        addr_a = {2'd0, 2'd3}; wdata_a = 32'd1 << ch; we_a = 1'b1;
      end
      @(negedge clk);
      we_a = 1'b0;
      if (k == clr_k) pend = 1'b0;
      if (is_exp(k, e, mode)) pend = 1'b1;
      tvec = '0;
      tvec[ch] = exp_tick(k, e, mode);
      checks++; if (tick_a !== tvec) begin
        failures++; $display("FAIL %s tick k=%0d got=%b required %b", name, k, tick_a, tvec);
      end
      checks++; if (irq_a !== (pend & ie)) begin
        failures++; $display("FAIL %s irq k=%0d got=%b required %b", name, k, irq_a, pend & ie);
      end
      st_exp = pend ? (32'd1 << ch) : 32'd0;
      rd_a(ch, 3, d);
      checks++; if (d !== st_exp) begin
        failures++; $display("FAIL %s status k=%0d got=%h required %h", name, k, d, st_exp);
      end
      rd_a(ch, 2, d);
      checks++; if (d !== 32'(exp_count(k, load, pre, mode))) begin
        failures++; $display("FAIL %s count k=%0d got=%0d required %0d", name, k, d, exp_count(k, load, pre, mode));
      end
      en_exp = (mode == 1 || mode == 2) ? 1'b1 : (k < e);
      rd_a(ch, 1, d);
      checks++; if (d[0] !== en_exp) begin
        failures++; $display("FAIL %s ctrl_en k=%0d got=%b required %b", name, k, d[0], en_exp);
      end
    end
  endtask

  task automatic test_random();
    int ch, load, pre, mode, n;
    bit ie;
    for (int it = 0; it < 6; it++) begin
      ch   = $urandom_range(0, 2);
      load = $urandom_range(0, 6);
      pre  = $urandom_range(0, 3);
      mode = $urandom_range(0, 3);
      ie   = 1'($urandom_range(0, 1));
      n    = 2 * (load + 1) * (pre + 1) + 4;
      test_channel_run("random", ch, load, pre, mode, ie, n, $urandom_range(1, n));
    end
  endtask

  task automatic test_square_rewrite();
    do_reset();
    wr_a(2, 0, 32'd1);
    wr_a(2, 1, 32'h0000_0005);
    @(negedge clk);
    @(negedge clk);
    checks++; if (tick_a[2] !== 1'b1) begin
      failures++; $display("FAIL sq_high_before_rewrite got=%b required 1", tick_a[2]);
    end
    wr_a(2, 1, 32'h0000_0005);
    checks++; if (tick_a[2] !== 1'b0) begin
      failures++; $display("FAIL sq_rewrite_low got=%b required 0", tick_a[2]);
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++; if (tick_a[2] !== exp_tick(j, 2, 2)) begin
        failures++; $display("FAIL sq_restart j=%0d got=%b required %b", j, tick_a[2], exp_tick(j, 2, 2));
      end
    end
  endtask

  task automatic test_load_collision();
    logic [31:0] d;
    do_reset();
    wr_a(0, 0, 32'd4);
    wr_a(0, 1, 32'h0000_000B);
    repeat (4) @(negedge clk);
    rd_a(0, 2, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL ldcol_pre_count got=%0d required 0", d); end
    wr_a(0, 0, 32'd2);
    checks++; if (tick_a[0] !== 1'b0 || irq_a !== 1'b0) begin
      failures++; $display("FAIL ldcol_no_expiry tick=%b irq=%b required 0/0", tick_a[0], irq_a);
    end
    rd_a(0, 3, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL ldcol_status got=%h required 0", d); end
    rd_a(0, 2, d);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL ldcol_count got=%0d required 2", d); end
    repeat (3) @(negedge clk);
    checks++; if (tick_a[0] !== 1'b1 || irq_a !== 1'b1) begin
      failures++; $display("FAIL ldcol_next_expiry tick=%b irq=%b required 1/1", tick_a[0], irq_a);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    do_reset();
    wr_a(0, 0, 32'd0);
    wr_a(0, 1, 32'h0000_0001);
    wr_a(3, 0, 32'h0000_0055);
    wr_a(3, 1, 32'h0000_000B);
    wr_a(3, 3, 32'hFFFF_FFFF);
    for (int rg = 0; rg < 4; rg++) begin
      rd_a(3, rg, d);
      checks++; if (d !== 32'd0) begin
        failures++; $display("FAIL oor_read reg%0d got=%h required 0", rg, d);
      end
    end
    rd_a(0, 3, d);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL oor_status_kept got=%h required 1", d); end
    for (int ch = 0; ch < 3; ch++) begin
      for (int rg = 0; rg < 3; rg++) begin
        rd_a(ch, rg, d);
        checks++; if (d !== 32'd0) begin
          failures++; $display("FAIL oor_no_alias ch%0d reg%0d got=%h required 0", ch, rg, d);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (tick_a !== 3'b000) begin failures++; $display("FAIL oor_tick got=%b required 000", tick_a); end
  endtask

  task automatic test_wide_periodic();
    int e;
    bit pend;
    logic [7:0]  tvec;
    logic [15:0] d, st_exp;
    int load;
    load = 4;
    do_reset();
    e = load + 1;
    pend = 1'b0;
    wr_b(7, 0, 16'(load));
    wr_b(7, 1, 16'h000B);
    for (int k = 1; k <= 22; k++) begin
      if (k == 12) begin
        addr_b = {3'd0, 2'd3}; wdata_b = 16'h0080; we_b = 1'b1;
      end
      @(negedge clk);
      we_b = 1'b0;
      if (k == 12) pend = 1'b0;
      if (is_exp(k, e, 1)) pend = 1'b1;
      tvec = '0;
      tvec[7] = exp_tick(k, e, 1);
      checks++; if (tick_b !== tvec) begin
        failures++; $display("FAIL wide tick k=%0d got=%b required %b", k, tick_b, tvec);
      end
      checks++; if (irq_b !== pend) begin
        failures++; $display("FAIL wide irq k=%0d got=%b required %b", k, irq_b, pend);
      end
      st_exp = pend ? 16'h0080 : 16'h0000;
      rd_b(7, 3, d);
      checks++; if (d !== st_exp) begin
        failures++; $display("FAIL wide status k=%0d got=%h required %h", k, d, st_exp);
      end
      rd_b(7, 2, d);
      checks++; if (d !== 16'(exp_count(k, load, 0, 1))) begin
        failures++; $display("FAIL wide count k=%0d got=%0d required %0d", k, d, exp_count(k, load, 0, 1));
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    we_a = 1'b0; addr_a = '0; wdata_a = '0;
    we_b = 1'b0; addr_b = '0; wdata_b = '0;
    test_reset();
    test_channel_run("periodic", 0, 4, 0, 1, 1'b1, 22, 12);
    test_channel_run("clr_collide", 0, 4, 0, 1, 1'b1, 12, 10);
    test_channel_run("oneshot_pre", 1, 3, 2, 0, 1'b1, 20, 0);
    test_channel_run("square", 2, 1, 0, 2, 1'b0, 12, 0);
    test_square_rewrite();
    test_load_collision();
    test_out_of_range();
    test_wide_periodic();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_array.md
# timer_array

Parametrised multi-channel down-counter/timer peripheral. It generalises the fixed three-channel counter on the I/O bus to CH channels of W bits. Each channel has its own prescaler, mode and interrupt enable, and the block keeps sticky per-channel pending flags behind a single IRQ line. It sits behind the MIO bus decoder: the bus supplies the write strobe, address and data; the CPU reads channel state back over rdata and takes `irq` as its interrupt input.

## Interface
- CH, default 3: number of channels, 1..8.
- W, default 32: counter and load register width, 8..32.
- AW, default $clog2(CH)+2 (min 3): address width, laid out as {channel index, reg[1:0]}.
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- we  in  1  register write strobe, one write per cycle.
- addr  in  AW  {ch, reg}:
  - reg 0 = LOAD
  - reg 1 = CTRL
  - reg 2 = COUNT (read-only)
  - reg 3 = STATUS (global, write-1-to-clear)
- wdata  in  W  write data.
- rdata  out  W  combinational read of the addressed register; 0 for ch >= CH; STATUS is zero-extended pending[CH-1:0].
- tick_out  out  CH  per-channel registered event output.
- irq  out  1  |(pending & ie), registered.

## Operation
- CTRL fields:
  - [0] EN
  - [2:1] MODE: 00 one-shot, 01 periodic, 10 square, 11 treated as one-shot
  - [3] IE
  - [15:8] PRE, prescale divisor minus 1
  - Other bits read 0.
- Per channel state: load, count, ctrl fields, prescale counter p (8 bits), pending, tick.
- Prescaler: while EN=1, p increments each cycle. When p==PRE, p returns to 0 and a step occurs in that cycle. While EN=0, p holds.
- Step behaviour:
  - count != 0: count <= count-1.
  - count == 0: expiry.
- Expiry:
  - pending <= 1.
  - Periodic/square: count <= load.
  - One-shot: count stays 0 and EN <= 0.
- tick_out:
  - One-shot and periodic: high for exactly one cycle after each expiry.
  - Square: toggles on each expiry.
- Period of periodic mode = (load+1)*(PRE+1) cycles. Load 0 gives an expiry every step.
- LOAD write: load <= wdata, count <= wdata, p <= 0. pending is unchanged.
- CTRL write: fields updated, p <= 0, count unchanged. A CTRL write also clears tick (square output restarts low).
- STATUS write: pending[i] <= 0 for each wdata[i]=1.
- Writes to ch >= CH are ignored.
- Simultaneous events:
  - Expiry and STATUS clear of the same bit in the same cycle: set wins.
  - LOAD/CTRL write to a channel in its step cycle: the write wins, and that step/expiry is discarded.
  - Independent channels never interact.
- Reset values: all registers 0. This gives tick_out=0, irq=0 and rdata for any implemented register = 0. Channels are disabled.

## Timing
- Register writes take effect on the clk edge where we=1; readback is visible from the next cycle.
- With PRE=0, the first step occurs on the first edge after the CTRL write that sets EN.
- Example: LOAD=2, PRE=0, periodic, EN written at edge t:
  - count is 1 after t+1 and 0 after t+2.
  - Expiry at t+3: count=2, pending=1, tick_out=1 during cycle t+3..t+4.
  - irq asserts the same edge as pending if IE=1.
- irq and tick_out are one cycle behind the expiry decision; no combinational path from bus inputs to them.
- Reset mid-count: all state clears asynchronously; no tick or irq afterwards until reprogrammed.
- Counter wrap: count never underflows. 0 is reloaded or held; W-bit arithmetic is unsigned.

## Test plan
- Reset: assert rstn=0 mid-operation with channel 0 running. Required: tick_out=0, irq=0, COUNT/CTRL/STATUS read 0 immediately and after release.
- Periodic: ch0 LOAD=4, CTRL=EN|periodic|IE, PRE=0. Required: tick_out[0] pulses every 5 cycles; irq=1 after first expiry and stays 1 until STATUS write 0x1, then re-asserts 5 cycles later.
- Prescaler + one-shot: ch1 LOAD=3, PRE=2, one-shot. Required: single expiry 12 cycles after enable; CTRL.EN reads 0 afterwards; COUNT holds 0; no further ticks.
- Square: ch2 LOAD=1, PRE=0, square. Required: tick_out[2] toggles every 2 cycles (period 4); CTRL rewrite forces it low.
- Collisions: STATUS clear coincident with ch0 expiry leaves pending[0]=1. LOAD write in ch0's expiry cycle loads the new value with no pending set.
- Out-of-range: CH=3, write addr ch=3. Required: no state change; rdata=0. Also repeat periodic test at CH=8, W=16.
